data_mem_resp: RTL
==================

// Module: data_mem_resp
// PURPOSE
//  Responder end of the CPU data-memory port: accepts word load/store requests
//  (ce/we/addr/wdata) from the core's MEM stage and serves them from an on-chip
//  word array after a programmable number of wait states, signalling completion
//  with a one-cycle rdy_o pulse. Flags misaligned and out-of-range accesses.
//  Sits between the core's data port and the board-level memory map.
// PARAMETERS
//  ADDR_W       10   word-address width; array depth = 2**ADDR_W words
//  WAIT_STATES  2    extra cycles between request accept and data access (0..15)
//  BASE_ADDR    0    byte address of word 0; accesses outside window -> error
// PORTS
//  clk      in   1   clock, all state updates on rising edge
//  rst      in   1   asynchronous reset, active-low (0 = reset)
//  ce_i     in   1   request valid; held by requester until rdy_o
//  we_i     in   1   1 = store, 0 = load; sampled at accept
//  addr_i   in   32  byte address; sampled at accept
//  data_i   in   32  store data; sampled at accept
//  data_o   out  32  load data; valid while rdy_o=1, held until next load
//  rdy_o    out  1   one-cycle completion pulse
//  err_o    out  1   qualifies rdy_o: misaligned / out-of-range, no access done
//  busy_o   out  1   1 while a request is in flight (state != IDLE)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, wait counter=0, data_o=0, rdy_o=0, err_o=0,
//    busy_o=0. Array contents are NOT reset. An in-flight request is aborted;
//    no store is committed unless its commit edge preceded reset assertion.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: if ce_i=1 at edge, latch we/addr/data; idx=(addr_i-BASE_ADDR)>>2.
//      error if addr_i[1:0]!=0 or addr_i<BASE_ADDR or idx>=2**ADDR_W:
//        go RESP with err flag; no access, data_o unchanged.
//      else cnt<=WAIT_STATES; go WAIT.
//    WAIT: if cnt!=0, cnt<=cnt-1; if cnt==0, perform access this edge
//      (store: mem[idx]<=wdata; load: data_o<=mem[idx]); go RESP.
//    RESP: rdy_o=1 (registered), err_o=err flag; next edge -> IDLE.
//  - Latency: accept edge to rdy_o high = WAIT_STATES+2 cycles for valid
//    accesses, 1 cycle for errors. Min back-to-back spacing: RESP->IDLE adds
//    one idle cycle; a request held at ce_i during RESP is NOT re-accepted
//    (requester must drop ce_i on the rdy_o cycle).
//  - ce_i/we_i/addr_i/data_i changes after accept are ignored until IDLE.
//  - Load following store to the same word returns the new value (store commits
//    before the later load's access edge by construction).
//  - rdy_o and err_o are low in all states except RESP. busy_o = (state!=IDLE).
//  - Address arithmetic is 32-bit unsigned; subtraction wrap is caught by the
//    addr_i<BASE_ADDR check. WAIT_STATES wider than the 4-bit counter is a
//    parameter error ($error at elaboration).
// STRUCTURE
//  - Shared package/header: state encodings (ST_IDLE=2'd0, ST_WAIT=2'd1,
//    ST_RESP=2'd2), word width 32, byte-offset width 2.
//  - One sub-module: dmem_array (single-port sync RAM, ADDR_W x 32, we/idx/
//    wdata/rdata), so the array can be swapped for a vendor macro. FSM, address
//    check and wait counter stay in data_mem_resp.
// TESTING
//  1. Reset: hold rst=0 5 cycles with ce_i=1 -> rdy_o=0, busy_o=0, data_o=0.
//  2. Store 0xDEADBEEF @0x10 then load @0x10 (WAIT_STATES=2) -> rdy_o 4 cycles
//     after each accept, err_o=0, load data_o=0xDEADBEEF.
//  3. Load @0x13 (misaligned) -> rdy_o=1, err_o=1 one cycle after accept;
//     data_o keeps previous value; mem[4] unchanged on re-read.
//  4. Store @BASE_ADDR+4*2**ADDR_W (0x1000 at defaults) -> err_o=1; no word
//     of the array modified (check words 0 and 1023).
//  5. Accept store 0x12345678 @0x20, drop rst during WAIT before commit ->
//     after reset, load @0x20 returns prior contents, not 0x12345678.
//  6. WAIT_STATES=0, ce_i held high continuously -> rdy_o pulses every 3
//     cycles (accept, access/RESP, idle), never two consecutive cycles.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e : responder FSM encodings (IDLE/WAIT/RESP)
//   WORD_W  : data word width
//   BOFF_W  : byte-offset bits inside a word
//   CNT_W   : wait-state counter width
package data_mem_resp_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BOFF_W = 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_resp_if.sv
// Core data-port bundle between the MEM-stage requester and the responder.
//   ce_i/we_i/addr_i/data_i : request (driven by master)
//   data_o/rdy_o/err_o/busy_o : response/status (driven by slave)
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic              ce_i;
  logic              we_i;
  logic [WORD_W-1:0] addr_i;
  logic [WORD_W-1:0] data_i;
  logic [WORD_W-1:0] data_o;
  logic              rdy_o;
  logic              err_o;
  logic              busy_o;

  modport master (
    output ce_i, we_i, addr_i, data_i,
    input  data_o, rdy_o, err_o, busy_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, data_i,
    output data_o, rdy_o, err_o, busy_o
  );
endinterface

// File: rtl/data_mem_resp_dmem_array.sv
// Single-port synchronous word RAM behind the responder; kept separate so a
// vendor macro can replace it.
//   clk, rst : clock; async active-low reset (read register only)
//   en, we   : access strobe; 1 = write, 0 = read
//   idx      : word index
//   wdata    : write data
//   rdata    : registered read data, held between reads
module dmem_array
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register only updates on a read, so the last load value is held.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Responder end of the CPU data-memory port. Accepts word load/store requests,
// waits WAIT_STATES cycles, performs the access on the array and pulses rdy_o
// for one cycle. Misaligned or out-of-window addresses complete with err_o and
// no access.
//   clk  : clock
//   rst  : asynchronous reset, active-low
//   bus  : data_mem_resp_if.slave (ce/we/addr/wdata in; data/rdy/err/busy out)
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  data_mem_resp_if.slave          bus
);

  if (WAIT_STATES > (2**CNT_W) - 1) begin : g_bad_wait_states
    $error("data_mem_resp: WAIT_STATES=%0d exceeds counter range", WAIT_STATES);
  end

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] idx_d, idx_q;
  logic [WORD_W-1:0] wdata_d, wdata_q;
  logic              rdy_d, rdy_q;
  logic              err_d, err_q;

  logic [WORD_W-1:0] word_off;
  logic              addr_err;
  logic              mem_en;
  logic [WORD_W-1:0] rdata;

  // Below-base addresses wrap to large offsets; the explicit compare catches
  // them even when the wrapped offset would land inside the window.
  assign word_off = (bus.addr_i - BASE_ADDR) >> BOFF_W;
  assign addr_err = (bus.addr_i[BOFF_W-1:0] != '0)
                 || (bus.addr_i < BASE_ADDR)
                 || ((word_off >> ADDR_W) != '0);

  assign mem_en = (state_q == ST_WAIT) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ce_i) begin
          we_d    = bus.we_i;
          wdata_d = bus.data_i;
          idx_d   = word_off[ADDR_W-1:0];
          if (addr_err) begin
            state_d = ST_RESP;
            rdy_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            cnt_d   = CNT_W'(WAIT_STATES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_RESP;
          rdy_d   = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en),
    .we    (we_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  assign bus.data_o = rdata;
  assign bus.rdy_o  = rdy_q;
  assign bus.err_o  = err_q;
  assign bus.busy_o = (state_q != ST_IDLE);

endmodule
